// File: rtl/mod_ctrl_pkg.sv
//------------------------------------------------------------------------------
// mod_ctrl_pkg : shared types, constants and helpers for the mod-M counter ctrl
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mod_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int C_WRAP_CNT_W = 8;

   // A modulus is usable when the counter can reach M-1 and M-1 >= 1.
   function automatic logic mod_is_legal(input int width, input int m);
      return (m >= 2) && (m <= (1 << width));
   endfunction

endpackage

`default_nettype wire

// File: rtl/mod_count_core.sv
//------------------------------------------------------------------------------
// mod_count_core : clearable, enabled up-counter that wraps at mod-1
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mod_count_core #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH:0]   mod,
   output logic [WIDTH-1:0] q,
   output logic             at_max
);

   logic [WIDTH-1:0] r_q;

   // Extra MSB lets mod = 2^WIDTH compare against an all-ones count.
   assign at_max = ({1'b0, r_q} == (mod - 1'b1));
   assign q      = r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= at_max ? '0 : r_q + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mod_counter_ctrl.sv
//------------------------------------------------------------------------------
// mod_counter_ctrl : host-facing sequencer for a programmable mod-M counter
// Optional wrap counter output enabled by macro MOD_CTRL_WRAP_COUNT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mod_counter_ctrl
   import mod_ctrl_pkg::*;
#(
   parameter int WIDTH       = 3,
   parameter int DEFAULT_MOD = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH:0]   cfg_mod,
   input  logic             cfg_oneshot,
   output logic             cfg_err,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy,
   output logic             done
`ifdef MOD_CTRL_WRAP_COUNT_EN
   ,
   output logic [C_WRAP_CNT_W-1:0] wrap_cnt
`endif
);

   state_t         r_state;
   logic [WIDTH:0] r_mod;
   logic           r_oneshot;
   logic           r_cfg_err;

   logic w_idle_or_done;
   logic w_xfer;
   logic w_legal;
   logic w_go;
   logic w_clr;
   logic w_en;
   logic w_at_max;

   assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_xfer         = cfg_valid && w_idle_or_done;
   assign w_legal        = mod_is_legal(WIDTH, int'(cfg_mod));
   assign w_go           = w_idle_or_done && start && !stop;

   // Counter is held at zero outside RUN/PAUSE; stop always wins over start.
   always_comb begin
      w_clr = 1'b0;
      w_en  = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: w_clr = 1'b1;
         ST_RUN:           w_en  = !stop;
         ST_PAUSE:         w_clr = stop;
         default:          w_clr = 1'b1;
      endcase
   end

   mod_count_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (w_clr),
      .en     (w_en),
      .mod    (r_mod),
      .q      (q),
      .at_max (w_at_max)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_mod     <= (WIDTH+1)'(DEFAULT_MOD);
         r_oneshot <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= w_xfer && !w_legal;
         if (w_xfer && w_legal) begin
            r_mod     <= cfg_mod;
            r_oneshot <= cfg_oneshot;
         end
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_go)        r_state <= ST_RUN;
               else if (w_xfer) r_state <= ST_IDLE;
            end
            ST_RUN: begin
               if (stop)                       r_state <= ST_PAUSE;
               else if (w_at_max && r_oneshot) r_state <= ST_DONE;
            end
            ST_PAUSE: begin
               if (stop)       r_state <= ST_IDLE;
               else if (start) r_state <= ST_RUN;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cfg_ready = w_idle_or_done;
   assign cfg_err   = r_cfg_err;
   assign tc        = (r_state == ST_RUN) && w_at_max;
   assign busy      = (r_state == ST_RUN) || (r_state == ST_PAUSE);
   assign done      = (r_state == ST_DONE);

`ifdef MOD_CTRL_WRAP_COUNT_EN
   logic [C_WRAP_CNT_W-1:0] r_wrap_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrap_cnt <= '0;
      end else if (w_go) begin
         r_wrap_cnt <= '0;
      end else if ((r_state == ST_RUN) && !stop && w_at_max && (r_wrap_cnt != '1)) begin
         r_wrap_cnt <= r_wrap_cnt + 1'b1;
      end
   end

   assign wrap_cnt = r_wrap_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_counter_ctrl.sv
//------------------------------------------------------------------------------
// tb_mod_counter_ctrl : directed + randomized bench with behavioural reference
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mod_counter_ctrl;

   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_valid = 1'b0;
   logic         cfg_ready;
   logic [W:0]   cfg_mod = '0;
   logic         cfg_oneshot = 1'b0;
   logic         cfg_err;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic [W-1:0] q;
   logic         tc;
   logic         busy;
   logic         done;
`ifdef MOD_CTRL_WRAP_COUNT_EN
   logic [7:0]   wrap_cnt;
`endif

   mod_counter_ctrl #(.WIDTH(W), .DEFAULT_MOD(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_mod     (cfg_mod),
      .cfg_oneshot (cfg_oneshot),
      .cfg_err     (cfg_err),
      .start       (start),
      .stop        (stop),
      .q           (q),
      .tc          (tc),
      .busy        (busy),
      .done        (done)
`ifdef MOD_CTRL_WRAP_COUNT_EN
      ,
      .wrap_cnt    (wrap_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Reference: phase 0=idle 1=run 2=pause 3=done
   int m_st, m_q, m_mod, m_one, m_err, m_wc;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_q = 0; m_mod = 6; m_one = 0; m_err = 0; m_wc = 0;
   endtask

   task automatic model_step();
      int  nst, nq;
      bit  xfer, legal;
      nst   = m_st;
      nq    = m_q;
      xfer  = cfg_valid && (m_st == 0 || m_st == 3);
      legal = (int'(cfg_mod) >= 2) && (int'(cfg_mod) <= (1 << W));
      m_err = int'(xfer && !legal);
      case (m_st)
         0, 3: begin
            if (xfer && legal) begin
               m_mod = int'(cfg_mod);
               m_one = int'(cfg_oneshot);
            end
            if (start && !stop) begin
               nst = 1; nq = 0; m_wc = 0;
            end else if (xfer) begin
               nst = 0;
            end
         end
         1: begin
            if (stop) nst = 2;
            else if (m_q == m_mod - 1) begin
               nq = 0;
               if (m_wc < 255) m_wc++;
               if (m_one != 0) nst = 3;
            end else nq = m_q + 1;
         end
         default: begin
            if (stop) begin nst = 0; nq = 0; end
            else if (start) nst = 1;
         end
      endcase
      m_st = nst;
      m_q  = nq;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("q",         int'(q),         m_q);
         chk("tc",        int'(tc),        int'(m_st == 1 && m_q == m_mod - 1));
         chk("busy",      int'(busy),      int'(m_st == 1 || m_st == 2));
         chk("cfg_ready", int'(cfg_ready), int'(m_st == 0 || m_st == 3));
         chk("done",      int'(done),      int'(m_st == 3));
         chk("cfg_err",   int'(cfg_err),   m_err);
`ifdef MOD_CTRL_WRAP_COUNT_EN
         chk("wrap_cnt",  int'(wrap_cnt),  m_wc);
`endif
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic cfg(input int m, input bit one);
      cfg_valid = 1'b1; cfg_mod = (W+1)'(m); cfg_oneshot = one;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   int exp6[8] = '{0, 1, 2, 3, 4, 5, 0, 1};

   initial begin
      model_reset();
      tick(2);
      chk("reset_q", int'(q), 0);
      chk("reset_ready", int'(cfg_ready), 1);
      chk("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // default modulus 6, periodic
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         chk("seq_m6", int'(q), exp6[i]);
         chk("tc_m6", int'(tc), int'(exp6[i] == 5));
         chk("busy_m6", int'(busy), 1);
         tick();
      end
      pulse_stop(); pulse_stop();

      // M=8 one-shot
      cfg(8, 1'b1);
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         chk("seq_m8", int'(q), i);
         tick();
      end
      chk("done_m8", int'(done), 1);
      chk("done_q", int'(q), 0);
      chk("done_ready", int'(cfg_ready), 1);
      tick(2);
      chk("done_hold", int'(done), 1);
      pulse_start();
      chk("done_clr", int'(done), 0);
      pulse_stop(); pulse_stop();

      // illegal moduli
      do_reset();
      cfg(1, 1'b0);
      chk("err_m1", int'(cfg_err), 1);
      tick();
      chk("err_m1_once", int'(cfg_err), 0);
      cfg(9, 1'b1);
      chk("err_m9", int'(cfg_err), 1);
      tick();
      chk("err_m9_once", int'(cfg_err), 0);
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         chk("seq_after_err", int'(q), i % 6);
         tick();
      end
      pulse_stop(); pulse_stop();

      // pause / resume / abort with M=5
      cfg(5, 1'b0);
      pulse_start();
      tick(3);
      chk("pause_pre", int'(q), 3);
      pulse_stop();
      for (int i = 0; i < 4; i++) begin
         chk("pause_q", int'(q), 3);
         chk("pause_tc", int'(tc), 0);
         tick();
      end
      pulse_start();
      chk("resume_q", int'(q), 3);
      tick(); chk("resume_4", int'(q), 4); chk("resume_tc", int'(tc), 1);
      tick(); chk("resume_0", int'(q), 0);
      tick(); chk("resume_1", int'(q), 1);
      pulse_stop(); pulse_stop();
      chk("abort_busy", int'(busy), 0);
      chk("abort_q", int'(q), 0);

      // simultaneous start & stop
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      chk("ss_idle", int'(busy), 0);
      pulse_start(); tick(); pulse_stop();
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      chk("ss_pause_busy", int'(busy), 0);
      chk("ss_pause_q", int'(q), 0);

      // asynchronous reset mid-run
      cfg(7, 1'b0);
      pulse_start();
      tick(4);
      chk("pre_rst_q", int'(q), 4);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_q", int'(q), 0);
      chk("async_rst_busy", int'(busy), 0);
`ifdef MOD_CTRL_WRAP_COUNT_EN
      chk("async_rst_wc", int'(wrap_cnt), 0);
`endif
      tick();
      rst_n = 1'b1;
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         chk("seq_after_rst", int'(q), i % 6);
         tick();
      end
      pulse_stop(); pulse_stop();

`ifdef MOD_CTRL_WRAP_COUNT_EN
      cfg(2, 1'b0);
      pulse_start();
      tick(520);
      chk("wc_sat", int'(wrap_cnt), 255);
      pulse_stop(); pulse_stop();
`endif

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         rst_n       = ($urandom_range(0, 499) != 0);
         cfg_valid   = ($urandom_range(0, 3) == 0);
         cfg_mod     = (W+1)'($urandom_range(0, 15));
         cfg_oneshot = 1'($urandom_range(0, 1));
         start       = ($urandom_range(0, 2) == 0);
         stop        = ($urandom_range(0, 7) == 0);
         tick();
      end
      rst_n = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
